// File: rtl/game_flow_ctrl.sv
// SkyHop game sequencer: start/play/fail/end flow, overlay enables,
// free-running one-second tick and 3-digit BCD score.
module game_flow_ctrl #(
  parameter int unsigned CLK_FREQ    = 65_000_000,
  parameter int unsigned FAIL_HOLD_S = 2,
  parameter int unsigned END_LOCK_S  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        space_pulse,
  input  logic        jump_ok,
  input  logic        jump_fail,
  output logic        start_en,
  output logic        game_en,
  output logic        end_en,
  output logic        fail_flag,
  output logic        game_rst,
  output logic        one_sec_tick,
  output logic [11:0] score
);

  localparam int unsigned CW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam int unsigned SMAX = (FAIL_HOLD_S > END_LOCK_S) ? FAIL_HOLD_S : END_LOCK_S;
  localparam int unsigned SW   = (SMAX > 1) ? $clog2(SMAX + 1) : 1;

  localparam logic [CW-1:0] TICK_LAST = CW'(CLK_FREQ - 1);
  localparam logic [SW-1:0] HOLD_N    = SW'(FAIL_HOLD_S);
  localparam logic [SW-1:0] LOCK_N    = SW'(END_LOCK_S);

  typedef enum logic [1:0] {
    ST_START,
    ST_PLAY,
    ST_FAIL,
    ST_END
  } state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic [CW-1:0] tick_nxt;
  logic [SW-1:0] sec_cnt;

  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] h, t, o;
    {h, t, o} = v;
    if (o != 4'd9) begin
      o = o + 4'd1;
    end else begin
      o = '0;
      if (t != 4'd9) begin
        t = t + 4'd1;
      end else begin
        t = '0;
        h = h + 4'd1;
      end
    end
    return {h, t, o};
  endfunction

  always_comb begin
    tick_nxt = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
  end

  // The tick is registered from the next count so it is high exactly
  // while the counter sits at its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt     <= '0;
      one_sec_tick <= 1'b0;
    end else begin
      tick_cnt     <= tick_nxt;
      one_sec_tick <= (tick_nxt == TICK_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_START;
      start_en  <= 1'b1;
      game_en   <= 1'b0;
      end_en    <= 1'b0;
      fail_flag <= 1'b0;
      game_rst  <= 1'b0;
      score     <= '0;
      sec_cnt   <= '0;
    end else begin
      game_rst <= 1'b0;
      unique case (state)
        ST_START: begin
          if (space_pulse) begin
            state     <= ST_PLAY;
            start_en  <= 1'b0;
            game_en   <= 1'b1;
            game_rst  <= 1'b1;
            score     <= '0;
            fail_flag <= 1'b0;
          end
        end
        ST_PLAY: begin
          // A fail in the same cycle as a landing wins; the landing is dropped.
          if (jump_fail) begin
            state     <= ST_FAIL;
            game_en   <= 1'b0;
            fail_flag <= 1'b1;
            sec_cnt   <= '0;
          end else if (jump_ok && score != 12'h999) begin
            score <= bcd_inc(score);
          end
        end
        ST_FAIL: begin
          if (sec_cnt >= HOLD_N) begin
            state   <= ST_END;
            end_en  <= 1'b1;
            sec_cnt <= '0;
          end else if (one_sec_tick) begin
            sec_cnt <= sec_cnt + 1'b1;
          end
        end
        ST_END: begin
          if (space_pulse && sec_cnt >= LOCK_N) begin
            state     <= ST_PLAY;
            end_en    <= 1'b0;
            game_en   <= 1'b1;
            game_rst  <= 1'b1;
            score     <= '0;
            fail_flag <= 1'b0;
          end else if (one_sec_tick && sec_cnt < LOCK_N) begin
            sec_cnt <= sec_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_START;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed, table-driven bench for game_flow_ctrl with a 10-cycle second.
module tb_game_flow_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        space_pulse;
  logic        jump_ok;
  logic        jump_fail;
  logic        start_en;
  logic        game_en;
  logic        end_en;
  logic        fail_flag;
  logic        game_rst;
  logic        one_sec_tick;
  logic [11:0] score;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic        sp, ok, fl;
    logic        st, ge, en, ff, gr;
    logic [11:0] sc;
  } vec_t;

  vec_t tbl[17];

  game_flow_ctrl #(
    .CLK_FREQ(10),
    .FAIL_HOLD_S(2),
    .END_LOCK_S(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .space_pulse(space_pulse),
    .jump_ok(jump_ok),
    .jump_fail(jump_fail),
    .start_en(start_en),
    .game_en(game_en),
    .end_en(end_en),
    .fail_flag(fail_flag),
    .game_rst(game_rst),
    .one_sec_tick(one_sec_tick),
    .score(score)
  );

  always #5 clk = ~clk;

  function automatic logic [16:0] pk(input logic st, ge, en, ff, gr, input logic [11:0] sc);
    return {st, ge, en, ff, gr, sc};
  endfunction

  function automatic logic [16:0] outs();
    return {start_en, game_en, end_en, fail_flag, game_rst, score};
  endfunction

  function automatic logic [11:0] bcd(input int d);
    logic [11:0] r;
    r[11:8] = 4'(d / 100);
    r[7:4]  = 4'((d / 10) % 10);
    r[3:0]  = 4'(d % 10);
    return r;
  endfunction

  task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got st/ge/en/ff/gr=%b score=%h, want st/ge/en/ff/gr=%b score=%h",
               name, act[16:12], act[11:0], exp[16:12], exp[11:0]);
    end
  endtask

  task automatic cyc(input logic sp, input logic ok, input logic fl);
    @(negedge clk);
    space_pulse = sp;
    jump_ok     = ok;
    jump_fail   = fl;
    @(posedge clk);
    #1;
  endtask

  // Caller has just observed the FAIL entry; space/ok/fail are hammered
  // throughout the hold and must all be ignored.
  task automatic wait_end(input string name, input logic [11:0] sc);
    int ticks = 0;
    bit done  = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (one_sec_tick) ticks++;
      cyc(1'b1, 1'b1, 1'b1);
      if (end_en) done = 1'b1;
      else chk({name, "_hold"}, outs(), pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, sc));
    end
    chk({name, "_timeout"}, {16'h0, done}, 17'd1);
    chk({name, "_ticks"}, 17'(ticks), 17'd2);
    chk({name, "_end"}, outs(), pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, sc));
  endtask

  task automatic leave_end(input string name, input logic [11:0] sc);
    bit seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (one_sec_tick) seen = 1'b1;
    end
    chk({name, "_tick_timeout"}, {16'h0, seen}, 17'd1);
    cyc(1'b1, 1'b0, 1'b0);
    chk({name, "_space_on_tick"}, outs(), pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, sc));
    cyc(1'b1, 1'b0, 1'b0);
    chk({name, "_to_play"}, outs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000));
    cyc(1'b0, 1'b0, 1'b0);
    chk({name, "_rst_done"}, outs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 12'h000};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000};
    for (int i = 4; i < 16; i++)
      tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, bcd(i - 3)};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h012};

    rst = 1'b1;
    space_pulse = 1'b0;
    jump_ok = 1'b0;
    jump_fail = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", outs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000));
    chk("reset_tick", {16'h0, one_sec_tick}, 17'd0);
    rst = 1'b0;

    // Counter is 0 after reset, so it reaches 9 on the 9th, 19th, 29th edge.
    for (int n = 1; n <= 30; n++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk($sformatf("tick_n%0d", n), {16'h0, one_sec_tick}, {16'h0, (n % 10) == 9});
    end
    chk("idle_start", outs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000));

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].sp, tbl[i].ok, tbl[i].fl);
      chk($sformatf("vec%0d", i), outs(),
          pk(tbl[i].st, tbl[i].ge, tbl[i].en, tbl[i].ff, tbl[i].gr, tbl[i].sc));
    end

    for (int d = 13; d <= 1001; d++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk($sformatf("score_%0d", d), outs(),
          pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, bcd(d > 999 ? 999 : d)));
    end

    cyc(1'b0, 1'b0, 1'b1);
    chk("fail_at_999", outs(), pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h999));
    wait_end("hold1", 12'h999);
    cyc(1'b1, 1'b0, 1'b0);
    chk("space_in_lock", outs(), pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h999));
    leave_end("lock1", 12'h999);

    for (int d = 1; d <= 5; d++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk($sformatf("replay_%0d", d), outs(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, bcd(d)));
    end
    cyc(1'b0, 1'b1, 1'b1);
    chk("fail_beats_ok", outs(), pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h005));
    wait_end("hold2", 12'h005);
    leave_end("lock2", 12'h005);

    for (int d = 1; d <= 3; d++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    chk("fail_at_003", outs(), pk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h003));
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_fail", outs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000));
    rst = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    chk("after_rst_start", outs(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
